vec_mem_stage: RTL

Memory-access stage of the vector pipeline, directly downstream of the EX/MEM pipeline register. It consumes that register's outputs (lane addresses, store data, memory controls, vector/scalar flag) and serialises scalar and 16-lane vector loads/stores onto a single-port, 32-bit, synchronous-read data memory. While an access is in flight it stalls upstream, and it presents the assembled load result to the MEM/WB stage.

---
 rtl/vec_mem_stage_if.sv | 27 ++
 rtl/vec_mem_stage.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/vec_mem_stage_if.sv
// Single-port synchronous data-memory bus between the vector memory stage and the data memory.
// Read data is expected one cycle after mem_re.
interface vec_mem_stage_if #(
    parameter int unsigned DW = 32
) ();
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_re;
    logic [DW-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        output mem_re,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        input  mem_re,
        output mem_rdata
    );
endinterface

// File: rtl/vec_mem_stage.sv
// Vector pipeline MEM stage: serialises scalar and LANES-wide vector loads/stores onto a
// single-port synchronous-read memory, stalling upstream until the access completes.
module vec_mem_stage #(
    parameter int unsigned LANES     = 16,
    parameter int unsigned DW        = 32,
    parameter int unsigned ADDR_STEP = 1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [LANES-1:0][DW-1:0]   ALUResultM,
    input  logic [LANES-1:0][DW-1:0]   WriteDataM,
    input  logic                       MemWriteM,
    input  logic                       MemtoRegM,
    input  logic                       v_s_m,
    vec_mem_stage_if.master            mem,
    output logic [LANES-1:0][DW-1:0]   ReadDataM,
    output logic                       StallM,
    output logic                       MemDoneM
);

    localparam int unsigned BW = $clog2(LANES);

    typedef enum logic [2:0] {StIdle, StVst, StVld, StCap, StDone} state_e;

    state_e                   state_q, state_d;
    logic [BW-1:0]            beat_q, beat_d;
    logic [DW-1:0]            base_q, base_d;
    logic                     vec_q, vec_d;
    logic [LANES-1:0][DW-1:0] wbuf_q, wbuf_d;
    logic [LANES-1:0][DW-1:0] rbuf_q, rbuf_d;
    logic [LANES-1:0][DW-1:0] rdata_q, rdata_d;

    logic          req, is_store, last_beat;
    logic [DW-1:0] beat_addr;
    logic [DW-1:0] addr_o, wdata_o;
    logic          we_o, re_o, stall_o, done_o;

    // Only lane 0 carries the base address; the other lane addresses are derived.
    logic unused_lane_addr;
    assign unused_lane_addr = ^ALUResultM[LANES-1:1];

    assign req       = MemWriteM | MemtoRegM;
    assign is_store  = MemWriteM;
    assign last_beat = (beat_q == BW'(LANES - 1));
    assign beat_addr = base_q + DW'(beat_q) * DW'(ADDR_STEP);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        base_d  = base_q;
        vec_d   = vec_q;
        wbuf_d  = wbuf_q;
        rbuf_d  = rbuf_q;
        rdata_d = rdata_q;
        addr_o  = '0;
        wdata_o = '0;
        we_o    = 1'b0;
        re_o    = 1'b0;
        stall_o = 1'b0;
        done_o  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    // Beat 0 goes straight from the pipeline register; later beats use latches.
                    addr_o  = ALUResultM[0];
                    wdata_o = WriteDataM[0];
                    we_o    = is_store;
                    re_o    = ~is_store;
                    base_d  = ALUResultM[0];
                    wbuf_d  = WriteDataM;
                    vec_d   = v_s_m;
                    if (is_store && !v_s_m) begin
                        done_o = 1'b1;
                    end else begin
                        stall_o = 1'b1;
                        if (v_s_m) begin
                            beat_d  = BW'(1);
                            state_d = is_store ? StVst : StVld;
                        end else begin
                            state_d = StCap;
                        end
                    end
                end
            end
            StVst: begin
                addr_o  = beat_addr;
                wdata_o = wbuf_q[beat_q];
                we_o    = 1'b1;
                if (last_beat) begin
                    done_o  = 1'b1;
                    beat_d  = '0;
                    state_d = StIdle;
                end else begin
                    stall_o = 1'b1;
                    beat_d  = beat_q + BW'(1);
                end
            end
            StVld: begin
                addr_o  = beat_addr;
                re_o    = 1'b1;
                stall_o = 1'b1;
                // Data returning now belongs to the previous beat.
                rbuf_d[beat_q - BW'(1)] = mem.mem_rdata;
                if (last_beat) begin
                    beat_d  = '0;
                    state_d = StCap;
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            StCap: begin
                stall_o = 1'b1;
                state_d = StDone;
                if (vec_q) begin
                    rbuf_d[LANES-1] = mem.mem_rdata;
                    rdata_d         = rbuf_d;
                end else begin
                    rbuf_d[0]  = mem.mem_rdata;
                    rdata_d    = '0;
                    rdata_d[0] = mem.mem_rdata;
                end
            end
            StDone: begin
                done_o  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (!RST) begin
            addr_o  = '0;
            wdata_o = '0;
            we_o    = 1'b0;
            re_o    = 1'b0;
            stall_o = 1'b0;
            done_o  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= StIdle;
            beat_q  <= '0;
            base_q  <= '0;
            vec_q   <= 1'b0;
            wbuf_q  <= '0;
            rbuf_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            base_q  <= base_d;
            vec_q   <= vec_d;
            wbuf_q  <= wbuf_d;
            rbuf_q  <= rbuf_d;
            rdata_q <= rdata_d;
        end
    end

    assign mem.mem_addr  = addr_o;
    assign mem.mem_wdata = wdata_o;
    assign mem.mem_we    = we_o;
    assign mem.mem_re    = re_o;
    assign ReadDataM     = rdata_q;
    assign StallM        = stall_o;
    assign MemDoneM      = done_o;

endmodule
